// File: rtl/rob_multi.sv
`default_nettype none
// ============================================================================
//  Module      : rob_multi
//  Description : Multi-lane reorder buffer. Circular queue of DEPTH entries
//                with DW-wide in-order dispatch, WB completion ports and
//                RW-wide in-order retirement. Tracks occupancy, applies
//                dispatch backpressure, and squashes younger entries with a
//                redirect pulse when a mispredicted entry retires.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, RST_N    clock, synchronous active-low reset
//    Flush         clear all entries, pointers back to 0
//    Disp_V/Data   per-lane dispatch request and opaque payload
//    Disp_Ready    free entries >= DW (uses registered Count)
//    Disp_Index    index each lane would be allocated (tail+k)
//    WB_*          completion ports: valid, index, mispredict flag, new PC
//    Ret_V/Data/Index  registered retire outputs, one-cycle valid
//    Redirect_V/PC registered redirect pulse on mispredict retire
//    Count/Empty/Full  registered occupancy and derived flags
// ============================================================================
module rob_multi #(
    parameter int DEPTH     = 128,
    parameter int IDX_W     = 7,
    parameter int DW        = 2,
    parameter int RW        = 2,
    parameter int WB        = 3,
    parameter int PAYLOAD_W = 44,
    parameter int PC_W      = 16
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    Flush,
    input  logic [DW-1:0]           Disp_V,
    input  logic [DW*PAYLOAD_W-1:0] Disp_Data,
    output logic                    Disp_Ready,
    output logic [DW*IDX_W-1:0]     Disp_Index,
    input  logic [WB-1:0]           WB_V,
    input  logic [WB*IDX_W-1:0]     WB_Index,
    input  logic [WB-1:0]           WB_Mispred,
    input  logic [WB*PC_W-1:0]      WB_NewPC,
    output logic [RW-1:0]           Ret_V,
    output logic [RW*PAYLOAD_W-1:0] Ret_Data,
    output logic [RW*IDX_W-1:0]     Ret_Index,
    output logic                    Redirect_V,
    output logic [PC_W-1:0]         Redirect_PC,
    output logic [IDX_W:0]          Count,
    output logic                    Empty,
    output logic                    Full
);

    localparam int              CNT_W       = IDX_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_DW_CNT    = CNT_W'(DW);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]          r_valid_q,   w_valid_d;
    logic [DEPTH-1:0]          r_done_q,    w_done_d;
    logic [DEPTH-1:0]          r_mispred_q, w_mispred_d;
    logic [PAYLOAD_W-1:0]      r_payload_mem [DEPTH];
    logic [PC_W-1:0]           r_newpc_mem   [DEPTH];

    logic [IDX_W-1:0]          r_head_q,  w_head_d;
    logic [IDX_W-1:0]          r_tail_q,  w_tail_d;
    logic [CNT_W-1:0]          r_count_q, w_count_d;

    logic [RW-1:0]             r_ret_v_q,       w_ret_v_d;
    logic [RW*PAYLOAD_W-1:0]   r_ret_data_q,    w_ret_data_d;
    logic [RW*IDX_W-1:0]       r_ret_index_q,   w_ret_index_d;
    logic                      r_redirect_v_q,  w_redirect_v_d;
    logic [PC_W-1:0]           r_redirect_pc_q, w_redirect_pc_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]          w_disp_idx [DW];
    logic [IDX_W-1:0]          w_ret_idx  [RW];
    logic [IDX_W-1:0]          w_wb_idx   [WB];

    logic                      w_disp_ready;
    logic                      w_gap;
    logic [DW-1:0]             w_acc_lane;
    logic [CNT_W-1:0]          w_acc_cnt;
    logic [DW-1:0]             w_disp_en;
    logic [CNT_W-1:0]          w_disp_cnt;

    logic                      w_chain;
    logic [RW-1:0]             w_ret_lane;
    logic [CNT_W-1:0]          w_ret_cnt;
    logic                      w_squash;
    logic [PC_W-1:0]           w_squash_pc;

    for (genvar k = 0; k < DW; k++) begin : g_disp_idx
        assign w_disp_idx[k]                 = r_tail_q + IDX_W'(k);
        assign Disp_Index[k*IDX_W +: IDX_W]  = w_disp_idx[k];
    end

    for (genvar r = 0; r < RW; r++) begin : g_ret_idx
        assign w_ret_idx[r] = r_head_q + IDX_W'(r);
    end

    for (genvar p = 0; p < WB; p++) begin : g_wb_idx
        assign w_wb_idx[p] = WB_Index[p*IDX_W +: IDX_W];
    end

    // Backpressure uses the registered count only; retires in this same
    // cycle do not free space until the next cycle.
    assign w_disp_ready = (c_DEPTH_CNT - r_count_q) >= c_DW_CNT;

    // Accept a contiguous run of lanes starting at lane 0.
    always_comb begin
        w_acc_lane = '0;
        w_acc_cnt  = '0;
        w_gap      = 1'b0;
        for (int k = 0; k < DW; k++) begin
            if (w_disp_ready && Disp_V[k] && !w_gap) begin
                w_acc_lane[k] = 1'b1;
                w_acc_cnt     = w_acc_cnt + c_ONE;
            end else begin
                w_gap = 1'b1;
            end
        end
    end

    // In-order retire scan. A mispredicted entry retires itself but stops
    // the scan, so at most one lane can trigger a squash per cycle.
    always_comb begin
        w_ret_lane  = '0;
        w_ret_cnt   = '0;
        w_squash    = 1'b0;
        w_squash_pc = '0;
        w_chain     = 1'b1;
        for (int r = 0; r < RW; r++) begin
            if (w_chain && r_valid_q[w_ret_idx[r]] && r_done_q[w_ret_idx[r]]) begin
                w_ret_lane[r] = 1'b1;
                w_ret_cnt     = w_ret_cnt + c_ONE;
                if (r_mispred_q[w_ret_idx[r]]) begin
                    w_squash    = 1'b1;
                    w_squash_pc = r_newpc_mem[w_ret_idx[r]];
                    w_chain     = 1'b0;
                end
            end else begin
                w_chain = 1'b0;
            end
        end
    end

    // Dispatch is dropped on a squash or flush in the same cycle.
    assign w_disp_en  = (Flush || w_squash) ? '0 : w_acc_lane;
    assign w_disp_cnt = (Flush || w_squash) ? '0 : w_acc_cnt;

    // ------------------------------------------------------------------
    // Per-entry flag next state. Order matters: writeback, then retire
    // clear, then squash/dispatch, then flush as the final override.
    // ------------------------------------------------------------------
    always_comb begin
        w_valid_d   = r_valid_q;
        w_done_d    = r_done_q;
        w_mispred_d = r_mispred_q;

        // Later ports overwrite earlier ones on an index collision.
        for (int p = 0; p < WB; p++) begin
            if (WB_V[p] && r_valid_q[w_wb_idx[p]]) begin
                w_done_d[w_wb_idx[p]]    = 1'b1;
                w_mispred_d[w_wb_idx[p]] = WB_Mispred[p];
            end
        end

        for (int r = 0; r < RW; r++) begin
            if (w_ret_lane[r]) begin
                w_valid_d[w_ret_idx[r]] = 1'b0;
                w_done_d[w_ret_idx[r]]  = 1'b0;
            end
        end

        if (w_squash) begin
            w_valid_d   = '0;
            w_done_d    = '0;
            w_mispred_d = '0;
        end else begin
            for (int k = 0; k < DW; k++) begin
                if (w_disp_en[k]) begin
                    w_valid_d[w_disp_idx[k]]   = 1'b1;
                    w_done_d[w_disp_idx[k]]    = 1'b0;
                    w_mispred_d[w_disp_idx[k]] = 1'b0;
                end
            end
        end

        if (Flush) begin
            w_valid_d   = '0;
            w_done_d    = '0;
            w_mispred_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Pointer, count and output next state
    // ------------------------------------------------------------------
    always_comb begin
        w_head_d        = r_head_q + IDX_W'(w_ret_cnt);
        w_tail_d        = r_tail_q + IDX_W'(w_disp_cnt);
        w_count_d       = r_count_q + w_disp_cnt - w_ret_cnt;
        w_ret_v_d       = w_ret_lane;
        w_ret_data_d    = r_ret_data_q;
        w_ret_index_d   = r_ret_index_q;
        w_redirect_v_d  = w_squash;
        w_redirect_pc_d = w_squash ? w_squash_pc : r_redirect_pc_q;

        for (int r = 0; r < RW; r++) begin
            if (w_ret_lane[r]) begin
                w_ret_data_d[r*PAYLOAD_W +: PAYLOAD_W] = r_payload_mem[w_ret_idx[r]];
                w_ret_index_d[r*IDX_W +: IDX_W]        = w_ret_idx[r];
            end
        end

        // Squash: younger entries are gone, allocation restarts at new head.
        if (w_squash) begin
            w_tail_d  = w_head_d;
            w_count_d = '0;
        end

        if (Flush) begin
            w_head_d        = '0;
            w_tail_d        = '0;
            w_count_d       = '0;
            w_ret_v_d       = '0;
            w_ret_data_d    = r_ret_data_q;
            w_ret_index_d   = r_ret_index_q;
            w_redirect_v_d  = 1'b0;
            w_redirect_pc_d = r_redirect_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_valid_q       <= '0;
            r_done_q        <= '0;
            r_mispred_q     <= '0;
            r_head_q        <= '0;
            r_tail_q        <= '0;
            r_count_q       <= '0;
            r_ret_v_q       <= '0;
            r_ret_data_q    <= '0;
            r_ret_index_q   <= '0;
            r_redirect_v_q  <= 1'b0;
            r_redirect_pc_q <= '0;
        end else begin
            r_valid_q       <= w_valid_d;
            r_done_q        <= w_done_d;
            r_mispred_q     <= w_mispred_d;
            r_head_q        <= w_head_d;
            r_tail_q        <= w_tail_d;
            r_count_q       <= w_count_d;
            r_ret_v_q       <= w_ret_v_d;
            r_ret_data_q    <= w_ret_data_d;
            r_ret_index_q   <= w_ret_index_d;
            r_redirect_v_q  <= w_redirect_v_d;
            r_redirect_pc_q <= w_redirect_pc_d;
        end
    end

    // Payload/new-PC storage needs no reset: contents are only observed
    // through entries whose valid/done/mispred flags are reset.
    always_ff @(posedge CLK) begin
        for (int p = 0; p < WB; p++) begin
            if (WB_V[p] && r_valid_q[w_wb_idx[p]]) begin
                r_newpc_mem[w_wb_idx[p]] <= WB_NewPC[p*PC_W +: PC_W];
            end
        end
        for (int k = 0; k < DW; k++) begin
            if (w_disp_en[k]) begin
                r_payload_mem[w_disp_idx[k]] <= Disp_Data[k*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Disp_Ready  = w_disp_ready;
    assign Ret_V       = r_ret_v_q;
    assign Ret_Data    = r_ret_data_q;
    assign Ret_Index   = r_ret_index_q;
    assign Redirect_V  = r_redirect_v_q;
    assign Redirect_PC = r_redirect_pc_q;
    assign Count       = r_count_q;
    assign Empty       = (r_count_q == '0);
    assign Full        = (r_count_q == c_DEPTH_CNT);

endmodule
`default_nettype wire

// File: tb/tb_rob_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_multi
//  Description : Self-checking bench for rob_multi. A queue-based model of
//                the buffer predicts every registered output after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_multi;

    localparam int DEPTH = 128;
    localparam int IDX_W = 7;
    localparam int DW    = 2;
    localparam int RW    = 2;
    localparam int WB    = 3;
    localparam int PW    = 44;
    localparam int PC_W  = 16;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic                 Flush;
    logic [DW-1:0]        Disp_V;
    logic [DW*PW-1:0]     Disp_Data;
    logic                 Disp_Ready;
    logic [DW*IDX_W-1:0]  Disp_Index;
    logic [WB-1:0]        WB_V;
    logic [WB*IDX_W-1:0]  WB_Index;
    logic [WB-1:0]        WB_Mispred;
    logic [WB*PC_W-1:0]   WB_NewPC;
    logic [RW-1:0]        Ret_V;
    logic [RW*PW-1:0]     Ret_Data;
    logic [RW*IDX_W-1:0]  Ret_Index;
    logic                 Redirect_V;
    logic [PC_W-1:0]      Redirect_PC;
    logic [IDX_W:0]       Count;
    logic                 Empty;
    logic                 Full;

    always #5 CLK = ~CLK;

    rob_multi #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .DW(DW), .RW(RW), .WB(WB),
        .PAYLOAD_W(PW), .PC_W(PC_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .Flush(Flush),
        .Disp_V(Disp_V), .Disp_Data(Disp_Data),
        .Disp_Ready(Disp_Ready), .Disp_Index(Disp_Index),
        .WB_V(WB_V), .WB_Index(WB_Index), .WB_Mispred(WB_Mispred),
        .WB_NewPC(WB_NewPC),
        .Ret_V(Ret_V), .Ret_Data(Ret_Data), .Ret_Index(Ret_Index),
        .Redirect_V(Redirect_V), .Redirect_PC(Redirect_PC),
        .Count(Count), .Empty(Empty), .Full(Full)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [PW-1:0]    pl;
        bit               done;
        bit               mp;
        logic [PC_W-1:0]  pc;
    } ent_t;

    ent_t             rob[$];          // oldest entry first
    int               m_head;
    logic [RW-1:0]    m_ret_v;
    logic [PW-1:0]    m_ret_data [RW];
    logic [IDX_W-1:0] m_ret_idx  [RW];
    bit               m_known    [RW];
    bit               m_rv;
    logic [PC_W-1:0]  m_rpc;
    bit               m_pc_known;

    int n_assert;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int  nret;
        bit  sq;
        bit  ready;
        ent_t e;
        if (!RST_N) begin
            rob.delete();
            m_head = 0; m_ret_v = '0; m_rv = 0; m_rpc = '0; m_pc_known = 1;
            for (int r = 0; r < RW; r++) begin
                m_ret_data[r] = '0; m_ret_idx[r] = '0; m_known[r] = 1;
            end
            return;
        end
        if (Flush) begin
            rob.delete();
            m_head = 0; m_ret_v = '0; m_rv = 0; m_pc_known = 0;
            for (int r = 0; r < RW; r++) m_known[r] = 0;
            return;
        end
        ready = (DEPTH - rob.size()) >= DW;
        nret = 0; sq = 0; m_ret_v = '0;
        for (int r = 0; r < RW && r < rob.size(); r++) begin
            if (!rob[r].done) break;
            m_ret_v[r]    = 1'b1;
            m_ret_data[r] = rob[r].pl;
            m_ret_idx[r]  = rob[r].idx;
            m_known[r]    = 1;
            nret++;
            if (rob[r].mp) begin
                sq = 1; m_rpc = rob[r].pc; m_pc_known = 1;
                break;
            end
        end
        for (int p = 0; p < WB; p++) begin
            if (WB_V[p]) begin
                for (int i = 0; i < rob.size(); i++) begin
                    if (rob[i].idx == WB_Index[p*IDX_W +: IDX_W]) begin
                        rob[i].done = 1;
                        rob[i].mp   = WB_Mispred[p];
                        rob[i].pc   = WB_NewPC[p*PC_W +: PC_W];
                    end
                end
            end
        end
        for (int i = 0; i < nret; i++) void'(rob.pop_front());
        m_head = (m_head + nret) % DEPTH;
        m_rv   = sq;
        if (sq) begin
            rob.delete();
        end else if (ready) begin
            for (int k = 0; k < DW; k++) begin
                if (!Disp_V[k]) break;
                e.idx  = IDX_W'((m_head + rob.size()) % DEPTH);
                e.pl   = Disp_Data[k*PW +: PW];
                e.done = 0; e.mp = 0; e.pc = '0;
                rob.push_back(e);
            end
        end
    endtask

    task automatic check_all();
        logic [DW*IDX_W-1:0] exp_di;
        int tail;
        tail = (m_head + rob.size()) % DEPTH;
        chk("count", Count, rob.size());
        chk("empty", Empty, rob.size() == 0);
        chk("full", Full, rob.size() == DEPTH);
        chk("disp_ready", Disp_Ready, (DEPTH - rob.size()) >= DW);
        for (int k = 0; k < DW; k++) exp_di[k*IDX_W +: IDX_W] = IDX_W'((tail + k) % DEPTH);
        chk("disp_index", Disp_Index, exp_di);
        chk("ret_v", Ret_V, m_ret_v);
        for (int r = 0; r < RW; r++) begin
            if (m_known[r]) begin
                chk("ret_data", Ret_Data[r*PW +: PW], m_ret_data[r]);
                chk("ret_index", Ret_Index[r*IDX_W +: IDX_W], m_ret_idx[r]);
            end
        end
        chk("redirect_v", Redirect_V, m_rv);
        if (m_pc_known) chk("redirect_pc", Redirect_PC, m_rpc);
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic idle();
        RST_N = 1'b1; Flush = 1'b0; Disp_V = '0; Disp_Data = '0;
        WB_V = '0; WB_Index = '0; WB_Mispred = '0; WB_NewPC = '0;
    endtask

    task automatic set_wb(input int p, input logic [IDX_W-1:0] idx, input bit mp,
                          input logic [PC_W-1:0] pc);
        WB_V[p] = 1'b1;
        WB_Index[p*IDX_W +: IDX_W] = idx;
        WB_Mispred[p] = mp;
        WB_NewPC[p*PC_W +: PC_W] = pc;
    endtask

    function automatic logic [PW-1:0] rnd_pl();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[PW-1:0];
    endfunction

    task automatic disp_rand(input logic [DW-1:0] v);
        Disp_V = v;
        Disp_Data = {rnd_pl(), rnd_pl()};
    endtask

    task automatic do_reset();
        idle(); RST_N = 1'b0; step(); step(); RST_N = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [IDX_W-1:0] base;
        int guard;
        n_assert = 0; n_fail = 0;

        // Reset then idle
        do_reset();
        idle(); step();
        chk("reset_count", Count, 0);
        chk("reset_disp_index", Disp_Index, 14'h0080);

        // Dual dispatch/retire with payloads 0xA/0xB
        Disp_V = 2'b11; Disp_Data = {44'hB, 44'hA}; step();
        chk("dual_count2", Count, 2);
        idle(); set_wb(0, 7'd0, 0, '0); set_wb(1, 7'd1, 0, '0); step();
        idle(); step();
        chk("dual_ret_v", Ret_V, 2'b11);
        chk("dual_ret_data", Ret_Data, {44'hB, 44'hA});
        chk("dual_count0", Count, 0);

        // Out-of-order completion
        base = IDX_W'(m_head + rob.size());
        disp_rand(2'b11); step(); disp_rand(2'b11); step();
        idle(); set_wb(0, base + 7'd1, 0, '0); step();
        idle(); step();
        chk("ooo_no_retire", Ret_V, 2'b00);
        set_wb(2, base, 0, '0); step();
        idle(); step();
        chk("ooo_pair", Ret_V, 2'b11);
        set_wb(0, base + 7'd2, 0, '0); set_wb(1, base + 7'd3, 0, '0); step();
        idle(); step();
        chk("ooo_tail_pair", Count, 0);

        // Full backpressure
        do_reset();
        for (int i = 0; i < 64; i++) begin idle(); disp_rand(2'b11); step(); end
        chk("full_count", Count, 128);
        chk("full_flag", Full, 1'b1);
        disp_rand(2'b11); step();
        chk("full_hold", Count, 128);
        idle(); set_wb(0, 7'd0, 0, '0); step();
        idle(); step();
        chk("full_127_blocked", Disp_Ready, 1'b0);
        set_wb(0, 7'd1, 0, '0); step();
        idle(); step();
        chk("full_126_ready", Disp_Ready, 1'b1);

        // Mispredict squash, with a same-cycle dispatch that must be dropped
        do_reset();
        for (int i = 0; i < 3; i++) begin idle(); disp_rand(2'b11); step(); end
        idle(); set_wb(0, 7'd0, 0, '0); set_wb(1, 7'd1, 1, 16'h1234); step();
        idle(); disp_rand(2'b11); step();
        chk("mp_redirect_v", Redirect_V, 1'b1);
        chk("mp_redirect_pc", Redirect_PC, 16'h1234);
        chk("mp_count", Count, 0);
        chk("mp_tail", Disp_Index, {7'd3, 7'd2});
        idle(); step();
        chk("mp_pulse_end", Redirect_V, 1'b0);

        // Same-index collision: highest port supplies mispred/newpc
        disp_rand(2'b01); step();
        idle(); set_wb(0, 7'd2, 1, 16'h1111); set_wb(2, 7'd2, 0, 16'h2222); step();
        idle(); step();
        chk("collide_no_redirect", Redirect_V, 1'b0);

        // Wrap-around
        do_reset();
        guard = 0;
        while (!(m_head == 127 && rob.size() == 0) && guard < 400) begin
            idle();
            if (m_head + rob.size() < 127) disp_rand(2'b01);
            if (rob.size() > 0) set_wb(0, rob[0].idx, 0, '0);
            step();
            guard++;
        end
        chk("wrap_reached", guard < 400, 1'b1);
        chk("wrap_disp_index", Disp_Index, {7'd0, 7'd127});
        disp_rand(2'b11); step();
        idle(); set_wb(0, 7'd127, 0, '0); set_wb(1, 7'd0, 0, '0); step();
        idle(); step();
        chk("wrap_ret_index", Ret_Index, {7'd0, 7'd127});
        for (int i = 0; i < 5; i++) begin idle(); disp_rand(2'b11); step(); end
        chk("pre_reset_count", Count, 10);
        idle(); RST_N = 1'b0; disp_rand(2'b11); step();
        chk("midreset_count", Count, 0);
        chk("midreset_empty", Empty, 1'b1);

        // Randomized traffic
        idle();
        for (int c = 0; c < 3000; c++) begin
            idle();
            RST_N = ($urandom_range(0, 499) != 0);
            Flush = ($urandom_range(0, 199) == 0);
            disp_rand(DW'($urandom_range(0, 3)));
            for (int p = 0; p < WB; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    if (rob.size() > 0 && $urandom_range(0, 7) != 0)
                        set_wb(p, rob[$urandom_range(0, rob.size() - 1)].idx,
                               ($urandom_range(0, 15) == 0), PC_W'($urandom()));
                    else
                        set_wb(p, IDX_W'($urandom()), ($urandom_range(0, 15) == 0),
                               PC_W'($urandom()));
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised successor reorder buffer: circular queue of DEPTH entries with DW-wide in-order dispatch, WB completion ports and RW-wide in-order retirement.
- Entry payload (ARF/RRF/CZ/SB/PC fields) is opaque, PAYLOAD_W bits wide, and is returned unchanged at retire.
- Adds an occupancy counter, a backpressure-based dispatch ready, and a mispredict redirect with a younger-entry squash at retire.
- Sits between decoder/dispatch, the execution units (ALUs, LSU) and the RRF/R_CZ/store-buffer retire logic.

Parameters:
- DEPTH, 128, number of entries; must equal 2**IDX_W.
- IDX_W, 7, entry index width.
- DW, 2, dispatch lanes per cycle.
- RW, 2, retire lanes per cycle.
- WB, 3, writeback/completion ports.
- PAYLOAD_W, 44, opaque entry payload width.
- PC_W, 16, redirect PC width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- Flush  in  1  external flush; clears the ROB at the next edge.
- Disp_V  in  DW  per-lane dispatch valid.
- Disp_Data  in  DW*PAYLOAD_W  lane k payload at bits [k*PAYLOAD_W +: PAYLOAD_W].
- Disp_Ready  out  1  combinational; 1 when free entries >= DW.
- Disp_Index  out  DW*IDX_W  combinational; index allocated to lane k = (tail+k) mod DEPTH.
- WB_V  in  WB  completion valid.
- WB_Index  in  WB*IDX_W  completing entry index.
- WB_Mispred  in  WB  entry is a mispredicted branch.
- WB_NewPC  in  WB*PC_W  correct target.
- Ret_V  out  RW  registered; lane r retired this cycle.
- Ret_Data  out  RW*PAYLOAD_W  registered retired payload.
- Ret_Index  out  RW*IDX_W  registered retired index.
- Redirect_V  out  1  registered, one-cycle pulse.
- Redirect_PC  out  PC_W  registered.
- Count  out  IDX_W+1  registered occupancy.
- Empty  out  1  Count==0.
- Full  out  1  Count==DEPTH.

Behaviour:
- Per-entry state: valid, done, mispred, newpc, payload. Pointers: head (oldest) and tail (next free), both IDX_W bits, wrapping modulo DEPTH by natural overflow.
- Reset (RST_N=0 at an edge): head=tail=0; Count=0; all valid/done/mispred=0; Ret_V=0; Ret_Data=0; Ret_Index=0; Redirect_V=0; Redirect_PC=0. Consequently Empty=1, Full=0, Disp_Ready=1. Reset has priority over Flush and all other inputs.
- Dispatch:
  - Lanes are accepted in order from lane 0 up to, but excluding, the first lane with Disp_V=0. Lanes after a gap are ignored.
  - Dispatch is accepted only when Disp_Ready=1. If Disp_Ready=0, all lanes are dropped; upstream must hold and retry.
  - Disp_Ready uses the registered Count; same-cycle retires are not credited.
  - An accepted lane k writes payload to entry tail+k with valid=1, done=0, mispred=0. Tail advances by the number of accepted lanes.
- Writeback:
  - On WB_V[p], the entry at WB_Index[p] gets done=1, mispred=WB_Mispred[p], newpc=WB_NewPC[p], provided the entry is valid. Writeback to an invalid entry is ignored.
  - If two ports target the same index in one cycle, the highest-numbered port supplies mispred/newpc.
  - A writeback becomes visible to retire one cycle later; retire evaluates pre-edge state.
- Retire:
  - Each cycle, examine entries head..head+RW-1. Lane r retires iff lanes 0..r-1 retired, the entry is valid and done, and no earlier lane in this cycle was mispredicted.
  - A retired entry is cleared (valid=0, done=0). Head advances by the retire count.
  - Ret_V/Ret_Data/Ret_Index are registered and valid for exactly one cycle. Unretired lanes drive Ret_V=0, and their Data/Index hold their last value.
- Mispredict squash: when a retiring lane has mispred=1, then at the same edge:
  - Redirect_V=1 and Redirect_PC=newpc.
  - All remaining entries are invalidated; tail=new head; Count=0.
  - Any same-cycle dispatch is dropped.
  - Redirect_V returns to 0 on the next cycle unless another squash occurs.
- Flush=1: same clearing as reset, except head/tail are set to 0 and Ret_V/Redirect_V=0. The Ret_Data/Redirect_PC values are don't-care.
- Count: Count_next = Count + accepted − retired. It is never negative; dispatch gating guarantees Count <= DEPTH.
- Wrap-around: indices wrap from DEPTH−1 to 0 for dispatch lane offsets, retire scan and pointer advance.
- Full/empty: Full blocks dispatch whenever DW>=1. Empty retires nothing, and Ret_V stays 0.

Test Plan:
- Reset then idle: RST_N=0 for 2 cycles, then 1 → Count=0, Empty=1, Disp_Ready=1, Ret_V=0, Disp_Index={1,0}.
- Dual dispatch/retire: dispatch 2 entries (payloads 0xA, 0xB); WB both at indices 0 and 1; next cycle → Ret_V=2'b11, Ret_Data lanes 0xA/0xB, Count goes 2→0.
- Out-of-order completion: dispatch 4 entries; complete index 1 only → no retire. Then complete index 0 → retire indices 0 and 1 together; then indices 2 and 3 after they complete.
- Full backpressure: dispatch 64 pairs with no WB → Count=128, Full=1, Disp_Ready=0. A further Disp_V=2'b11 leaves Count=128. Completing and retiring index 0 → Disp_Ready=0 until Count<=126.
- Mispredict: dispatch indices 0–5; WB index 1 with WB_Mispred=1, NewPC=0x1234, and index 0 done → retire lanes 0 and 1; Redirect_V pulse with PC 0x1234; Count=0; tail=head=2.
- Wrap and mid-operation reset: advance head/tail to 127 → Disp_Index={0,127}; retire across the wrap correctly. Then assert RST_N=0 with Count=10 → all state cleared at the next edge.
